// File: rtl/tpiu_pkg.sv
// rtl/tpiu_pkg.sv - shared TPIU frame geometry and frame type.
package tpiu_pkg;
  localparam int TPIU_FRAME_BYTES     = 16;
  localparam int TPIU_WORDS_PER_FRAME = 8;
  localparam int TPIU_FRAME_W         = 128;

  typedef logic [TPIU_FRAME_W-1:0] tpiu_frame_t;
endpackage

// File: rtl/tpiu_frame_assembler_fifo.sv
// rtl/tpiu_frame_assembler_fifo.sv - frame_fifo: power-of-two frame queue, valid/ready both sides.
module frame_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 128,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         full,
  output logic         empty
);
  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic push, pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign in_ready  = !full || pop;
  assign push      = in_valid && in_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: rtl/tpiu_frame_assembler.sv
// rtl/tpiu_frame_assembler.sv - packs 8 trace words into 16-byte frames and queues them.
// Optional lost-frame counter port enabled by TPIU_LOSTCNT_EN.
module tpiu_frame_assembler
  import tpiu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                    traceClkin,
  input  logic                    rstn,
  input  logic                    WdAvail,
  input  logic [15:0]             PacketWd,
  input  logic                    PacketReset,
  output logic                    FrameValid,
  output logic [TPIU_FRAME_W-1:0] FrameData,
  input  logic                    FrameReady,
  output logic                    Synced,
`ifdef TPIU_LOSTCNT_EN
  output logic [15:0]             LostFrames,
`endif
  output logic                    Overflow
);
  localparam int ASM_W = TPIU_FRAME_W - 16;

  logic [2:0]       word_idx_q, word_idx_d;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic             synced_q, synced_d;
  logic             overflow_q;
  logic             complete, fifo_in_ready, drop;
  logic             fifo_full, fifo_empty;
  tpiu_frame_t      frame;

  always_comb begin
    synced_d   = synced_q;
    word_idx_d = word_idx_q;
    asm_d      = asm_q;
    complete   = 1'b0;
    if (PacketReset) begin
      synced_d   = 1'b1;
      word_idx_d = '0;
    end else if (WdAvail && synced_q) begin
      if (word_idx_q == 3'd7) begin
        complete   = 1'b1;
        word_idx_d = '0;
      end else begin
        asm_d[{word_idx_q, 4'b0000} +: 16] = PacketWd;
        word_idx_d = word_idx_q + 3'd1;
      end
    end
  end

  // The final word bypasses the assembly register straight into the queue.
  assign frame = {PacketWd, asm_q};
  assign drop  = complete && !fifo_in_ready;

  always_ff @(posedge traceClkin or negedge rstn) begin
    if (!rstn) begin
      word_idx_q <= '0;
      asm_q      <= '0;
      synced_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      word_idx_q <= word_idx_d;
      asm_q      <= asm_d;
      synced_q   <= synced_d;
      overflow_q <= drop;
    end
  end

`ifdef TPIU_LOSTCNT_EN
  logic [15:0] lost_q;
  always_ff @(posedge traceClkin or negedge rstn) begin
    if (!rstn)                       lost_q <= '0;
    else if (drop && lost_q != '1)   lost_q <= lost_q + 16'd1;
  end
  assign LostFrames = lost_q;
`endif

  frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TPIU_FRAME_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (traceClkin),
    .rst_n     (rstn),
    .in_valid  (complete),
    .in_data   (frame),
    .in_ready  (fifo_in_ready),
    .out_valid (FrameValid),
    .out_data  (FrameData),
    .out_ready (FrameReady),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign Synced   = synced_q;
  assign Overflow = overflow_q;

  logic unused_flags;
  assign unused_flags = fifo_full ^ fifo_empty;
endmodule
